// File: rtl/axi_arb_pkg.sv
// Shared definitions for the two-master AXI read-address arbiter.
//   arb_state_e : arbiter FSM states (IDLE = free to choose, LOCKED = grant held)
//   LSU / DBG   : master index constants (LSU = 0, DBG = debug/system bus = 1)
//   CNT_W       : width of the per-master outstanding-read counters
package axi_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam logic LSU   = 1'b0;
    localparam logic DBG   = 1'b1;
    localparam int   CNT_W = 4;

endpackage

// File: rtl/axi_rd_outst_cnt.sv
// Saturating outstanding-read counter for one master.
// Ports:
//   clk, reset_l : clock, asynchronous active-low reset
//   inc          : AR handshake for this master this cycle
//   dec          : last R beat for this master accepted this cycle
//   cnt          : current number of outstanding reads
//   avail        : cnt is below MAX_OUTST, so another read may be issued
module axi_rd_outst_cnt
    import axi_arb_pkg::*;
#(
    parameter int MAX_OUTST = 4
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             avail
);

    logic do_inc;
    logic do_dec;

    // A simultaneous issue and retire cancel out; the limits guard against
    // stray R beats (count stays at 0) and any increment past the maximum.
    assign do_inc = inc && !dec && (cnt < CNT_W'(MAX_OUTST));
    assign do_dec = dec && !inc && (cnt != '0);
    assign avail  = (cnt < CNT_W'(MAX_OUTST));

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            cnt <= '0;
        end else if (do_inc) begin
            cnt <= cnt + CNT_W'(1);
        end else if (do_dec) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter (master 0 = LSU, master 1 = debug/system bus).
// AR channel: round-robin between eligible masters, grant locked while the
// slave stalls an issued address. R channel: routed back by the RID MSB.
// Both channels are combinational (zero latency).
// Ports:
//   clk, reset_l                 : clock, asynchronous active-low reset
//   m_arvalid/m_arid/m_araddr    : per-master AR request (packed by master index)
//   m_arready                    : per-master AR ready
//   m_rvalid/m_rready            : per-master R handshake
//   m_rdata/m_rid/m_rresp/m_rlast: R payload broadcast to both masters
//   s_ar*                        : slave AR channel, s_arid = {grant, master ARID}
//   s_r*                         : slave R channel, s_rid MSB = destination master
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int M_ID_WIDTH = 8,
    parameter int MAX_OUTST  = 4
) (
    input  logic                    clk,
    input  logic                    reset_l,
    input  logic [1:0]              m_arvalid,
    input  logic [2*M_ID_WIDTH-1:0] m_arid,
    input  logic [63:0]             m_araddr,
    output logic [1:0]              m_arready,
    output logic [1:0]              m_rvalid,
    input  logic [1:0]              m_rready,
    output logic [63:0]             m_rdata,
    output logic [M_ID_WIDTH-1:0]   m_rid,
    output logic [1:0]              m_rresp,
    output logic                    m_rlast,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [M_ID_WIDTH:0]     s_arid,
    output logic [31:0]             s_araddr,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [M_ID_WIDTH:0]     s_rid,
    input  logic [63:0]             s_rdata,
    input  logic [1:0]              s_rresp,
    input  logic                    s_rlast
);

    arb_state_e       state;
    logic             owner;
    logic             rr;
    logic             gnt;
    logic             gnt_vld;
    logic [1:0]       avail;
    logic [1:0]       elig;
    logic [CNT_W-1:0] outst_cnt [2];
    logic             ar_hs;
    logic             r_dst;
    logic             r_last_hs;

    assign elig = m_arvalid & avail;

    // While LOCKED the stalled address must stay stable, so eligibility and
    // the round-robin pointer are ignored until the slave accepts it.
    always_comb begin
        gnt     = LSU;
        gnt_vld = 1'b0;
        if (state == LOCKED) begin
            gnt     = owner;
            gnt_vld = 1'b1;
        end else if (elig[LSU] && elig[DBG]) begin
            gnt     = rr;
            gnt_vld = 1'b1;
        end else if (elig[DBG]) begin
            gnt     = DBG;
            gnt_vld = 1'b1;
        end else begin
            gnt     = LSU;
            gnt_vld = elig[LSU];
        end
    end

    // Every valid/ready output is qualified by reset_l so they drop to 0 the
    // moment reset asserts, independent of the (combinational) inputs.
    assign s_arvalid = reset_l && gnt_vld && m_arvalid[gnt];
    assign s_araddr  = gnt ? m_araddr[63:32] : m_araddr[31:0];
    assign s_arid    = {gnt, (gnt ? m_arid[2*M_ID_WIDTH-1:M_ID_WIDTH]
                                  : m_arid[M_ID_WIDTH-1:0])};
    assign ar_hs     = s_arvalid && s_arready;

    always_comb begin
        m_arready      = '0;
        m_arready[gnt] = reset_l && gnt_vld && s_arready;
    end

    assign r_dst     = s_rid[M_ID_WIDTH];
    assign s_rready  = reset_l && m_rready[r_dst];
    assign r_last_hs = s_rvalid && s_rready && s_rlast;
    assign m_rid     = s_rid[M_ID_WIDTH-1:0];
    assign m_rdata   = s_rdata;
    assign m_rresp   = s_rresp;
    assign m_rlast   = s_rlast;

    always_comb begin
        m_rvalid        = '0;
        m_rvalid[r_dst] = reset_l && s_rvalid;
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
            owner <= LSU;
            rr    <= LSU;
        end else begin
            if (ar_hs) begin
                rr <= ~gnt;
            end
            case (state)
                IDLE: begin
                    if (s_arvalid && !s_arready) begin
                        state <= LOCKED;
                        owner <= gnt;
                    end
                end
                LOCKED: begin
                    if (ar_hs) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_cnt
        axi_rd_outst_cnt #(
            .MAX_OUTST(MAX_OUTST)
        ) u_cnt (
            .clk    (clk),
            .reset_l(reset_l),
            .inc    (ar_hs && (gnt == 1'(i))),
            .dec    (r_last_hs && (r_dst == 1'(i))),
            .cnt    (outst_cnt[i]),
            .avail  (avail[i])
        );
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Testbench for axi_rd_arbiter: vector table with a scoreboard queue, followed
// by hand-written sequences for lock hold, reset while locked and stray R beats.
module tb_axi_rd_arbiter;
    import axi_arb_pkg::*;

    localparam int W    = 8;
    localparam int MAXO = 2;

    logic          clk = 1'b0;
    logic          reset_l = 1'b0;
    logic [1:0]    m_arvalid;
    logic [2*W-1:0] m_arid;
    logic [63:0]   m_araddr;
    logic [1:0]    m_arready;
    logic [1:0]    m_rvalid;
    logic [1:0]    m_rready;
    logic [63:0]   m_rdata;
    logic [W-1:0]  m_rid;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          s_arvalid;
    logic          s_arready;
    logic [W:0]    s_arid;
    logic [31:0]   s_araddr;
    logic          s_rvalid;
    logic          s_rready;
    logic [W:0]    s_rid;
    logic [63:0]   s_rdata;
    logic [1:0]    s_rresp;
    logic          s_rlast;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.M_ID_WIDTH(W), .MAX_OUTST(MAXO)) dut (
        .clk(clk), .reset_l(reset_l),
        .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr),
        .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_rdata(m_rdata), .m_rid(m_rid), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast)
    );

    typedef struct {
        logic [1:0]  arv;  logic sar; logic rv; logic [8:0] rid; logic rl; logic [1:0] rrdy;
        logic [1:0]  e_ard; logic e_sav; logic [31:0] e_addr; logic [8:0] e_id;
        logic [1:0]  e_rv;  logic e_srr; logic [7:0] e_rid; logic [3:0] e_c0; logic [3:0] e_c1;
    } vec_t;

    vec_t vecs[13];
    vec_t sbq[$];

    function automatic vec_t mk(logic [1:0] arv, logic sar, logic rv, logic [8:0] rid,
                                logic rl, logic [1:0] rrdy, logic [1:0] ard, logic sav,
                                logic [31:0] addr, logic [8:0] id, logic [1:0] erv,
                                logic srr, logic [7:0] erid, logic [3:0] c0, logic [3:0] c1);
        vec_t v;
        v.arv = arv; v.sar = sar; v.rv = rv; v.rid = rid; v.rl = rl; v.rrdy = rrdy;
        v.e_ard = ard; v.e_sav = sav; v.e_addr = addr; v.e_id = id;
        v.e_rv = erv; v.e_srr = srr; v.e_rid = erid; v.e_c0 = c0; v.e_c1 = c1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [1:0] arv, input logic sar, input logic rv,
                       input logic [8:0] rid, input logic rl, input logic [1:0] rrdy);
        m_arvalid = arv; s_arready = sar; s_rvalid = rv;
        s_rid = rid; s_rlast = rl; m_rready = rrdy;
    endtask

    // One granted-address check: ready vector, valid, and (when valid) the
    // address and {grant, ARID} seen by the slave.
    task automatic check_ar(input string name, input logic [1:0] ard, input logic sav,
                            input logic [31:0] addr, input logic [8:0] id);
        if (sav)
            check(name, {m_arready, s_arvalid, s_araddr, s_arid}, {ard, sav, addr, id});
        else
            check(name, {m_arready, s_arvalid}, {ard, sav});
    endtask

    initial begin
        m_araddr = {32'h0000_2000, 32'h0000_1000};
        m_arid   = {8'h22, 8'h11};
        s_rdata  = '0;
        s_rresp  = '0;
        // Inputs active during reset: outputs must still be held at 0.
        drv(2'b11, 1'b1, 1'b1, 9'h100, 1'b1, 2'b11);

        //               arv   sar  rv  rid     rl  rrdy   ard    sav addr          id      erv    srr erid   c0 c1
        vecs[0]  = mk(2'b11, 1, 0, 9'h000, 0, 2'b00, 2'b01, 1, 32'h1000, 9'h011, 2'b00, 0, 8'h00, 0, 0);
        vecs[1]  = mk(2'b11, 1, 0, 9'h000, 0, 2'b00, 2'b10, 1, 32'h2000, 9'h122, 2'b00, 0, 8'h00, 1, 0);
        vecs[2]  = mk(2'b11, 1, 0, 9'h000, 0, 2'b00, 2'b01, 1, 32'h1000, 9'h011, 2'b00, 0, 8'h00, 1, 1);
        vecs[3]  = mk(2'b11, 1, 0, 9'h000, 0, 2'b00, 2'b10, 1, 32'h2000, 9'h122, 2'b00, 0, 8'h00, 2, 1);
        vecs[4]  = mk(2'b00, 1, 1, 9'h15A, 1, 2'b10, 2'b00, 0, 32'h0,    9'h000, 2'b10, 1, 8'h5A, 2, 2);
        vecs[5]  = mk(2'b11, 1, 0, 9'h000, 0, 2'b00, 2'b10, 1, 32'h2000, 9'h122, 2'b00, 0, 8'h00, 2, 1);
        vecs[6]  = mk(2'b01, 1, 1, 9'h033, 1, 2'b01, 2'b00, 0, 32'h0,    9'h000, 2'b01, 1, 8'h33, 2, 2);
        vecs[7]  = mk(2'b01, 1, 0, 9'h000, 0, 2'b00, 2'b01, 1, 32'h1000, 9'h011, 2'b00, 0, 8'h00, 1, 2);
        vecs[8]  = mk(2'b00, 0, 1, 9'h044, 1, 2'b01, 2'b00, 0, 32'h0,    9'h000, 2'b01, 1, 8'h44, 2, 2);
        vecs[9]  = mk(2'b01, 1, 1, 9'h055, 1, 2'b01, 2'b01, 1, 32'h1000, 9'h011, 2'b01, 1, 8'h55, 1, 2);
        vecs[10] = mk(2'b00, 0, 1, 9'h166, 1, 2'b01, 2'b00, 0, 32'h0,    9'h000, 2'b10, 0, 8'h66, 1, 2);
        vecs[11] = mk(2'b00, 0, 1, 9'h177, 0, 2'b10, 2'b00, 0, 32'h0,    9'h000, 2'b10, 1, 8'h77, 1, 2);
        vecs[12] = mk(2'b00, 0, 0, 9'h000, 0, 2'b00, 2'b00, 0, 32'h0,    9'h000, 2'b00, 0, 8'h00, 1, 2);

        #3;
        check("rst_ar_outputs", {m_arready, s_arvalid}, 3'b000);
        check("rst_r_outputs", {m_rvalid, s_rready}, 3'b000);
        check("rst_state_rr_owner", {64'(dut.state), 64'(dut.rr), 64'(dut.owner)} , 0);
        check("rst_counts", {dut.outst_cnt[1], dut.outst_cnt[0]}, 8'h00);

        @(posedge clk); #1;
        reset_l = 1'b1;

        for (int i = 0; i < 13; i++) begin
            vec_t e;
            drv(vecs[i].arv, vecs[i].sar, vecs[i].rv, vecs[i].rid, vecs[i].rl, vecs[i].rrdy);
            s_rdata = 64'hA5A5_0000_0000_0000 | 64'(i);
            s_rresp = 2'(i);
            sbq.push_back(vecs[i]);
            @(negedge clk);
            e = sbq.pop_front();
            check_ar($sformatf("vec%0d_ar", i), e.e_ard, e.e_sav, e.e_addr, e.e_id);
            check($sformatf("vec%0d_r", i), {m_rvalid, s_rready, m_rid}, {e.e_rv, e.e_srr, e.e_rid});
            check($sformatf("vec%0d_cnt", i), {dut.outst_cnt[1], dut.outst_cnt[0]}, {e.e_c1, e.e_c0});
            check($sformatf("vec%0d_payload", i), {m_rdata, m_rresp, m_rlast},
                  {64'hA5A5_0000_0000_0000 | 64'(i), 2'(i), e.rl});
            @(posedge clk); #1;
        end

        // Reset while LOCKED: outputs drop in the same cycle.
        drv(2'b01, 1'b0, 1'b0, 9'h000, 1'b0, 2'b00);
        @(negedge clk);
        check_ar("lk0_grant", 2'b00, 1'b1, 32'h1000, 9'h011);
        @(posedge clk); #1;
        check("lk0_state_locked", 64'(dut.state), 64'(LOCKED));
        drv(2'b01, 1'b0, 1'b1, 9'h100, 1'b1, 2'b11);
        #1 reset_l = 1'b0;
        #1;
        check("midrst_ar_outputs", {m_arready, s_arvalid}, 3'b000);
        check("midrst_r_outputs", {m_rvalid, s_rready}, 3'b000);
        check("midrst_state", 64'(dut.state), 64'(IDLE));
        check("midrst_counts", {dut.outst_cnt[1], dut.outst_cnt[0]}, 8'h00);

        // Release: first grant follows rr = 0; stray R beat for master 1 (count 0).
        @(posedge clk); #1;
        reset_l = 1'b1;
        drv(2'b11, 1'b0, 1'b1, 9'h1AB, 1'b1, 2'b10);
        @(negedge clk);
        check("rel_state_idle", 64'(dut.state), 64'(IDLE));
        check_ar("rel_first_grant", 2'b00, 1'b1, 32'h1000, 9'h011);
        check("stray_r_route", {m_rvalid, s_rready, m_rid}, {2'b10, 1'b1, 8'hAB});
        @(posedge clk); #1;

        // Lock hold with master 1 also requesting.
        drv(2'b11, 1'b0, 1'b0, 9'h000, 1'b0, 2'b00);
        @(negedge clk);
        check("stray_r_cnt1_zero", 64'(dut.outst_cnt[1]), 0);
        check_ar("hold_c2", 2'b00, 1'b1, 32'h1000, 9'h011);
        @(posedge clk); #1;
        @(negedge clk);
        check_ar("hold_c3", 2'b00, 1'b1, 32'h1000, 9'h011);
        @(posedge clk); #1;
        s_arready = 1'b1;
        @(negedge clk);
        check_ar("hold_handshake", 2'b01, 1'b1, 32'h1000, 9'h011);
        @(posedge clk); #1;
        @(negedge clk);
        check_ar("after_lock_m1", 2'b10, 1'b1, 32'h2000, 9'h122);
        @(posedge clk); #1;

        // Lock owned by master 1 must override rr = 0 when master 0 arrives.
        drv(2'b10, 1'b0, 1'b0, 9'h000, 1'b0, 2'b00);
        @(negedge clk);
        check_ar("lk1_grant", 2'b00, 1'b1, 32'h2000, 9'h122);
        @(posedge clk); #1;
        m_arvalid = 2'b11;
        @(negedge clk);
        check_ar("lk1_hold_vs_rr", 2'b00, 1'b1, 32'h2000, 9'h122);
        @(posedge clk); #1;
        s_arready = 1'b1;
        @(negedge clk);
        check_ar("lk1_handshake", 2'b10, 1'b1, 32'h2000, 9'h122);
        @(posedge clk); #1;

        // Master 1 at its limit, master 0 idle: nothing is granted.
        drv(2'b10, 1'b0, 1'b0, 9'h000, 1'b0, 2'b00);
        @(negedge clk);
        check("limit_cnt1", 64'(dut.outst_cnt[1]), 64'(MAXO));
        check_ar("limit_no_grant", 2'b00, 1'b0, 32'h0, 9'h000);
        @(posedge clk); #1;
        @(negedge clk);
        check("limit_state_idle", 64'(dut.state), 64'(IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish, want finish before 50000");
        $fatal(1);
    end

endmodule
